// File: rtl/rng_pool.sv
// rng_pool
// Buffering stage that sits directly downstream of the rng block.
// - Enables the RNG and captures every word it presents with ready.
// - Whitens each captured word by XOR with the previous raw word.
// - Drops stuck (repeated) raw words.
// - Buffers results in a first-word-fall-through FIFO.
// A hysteresis fill controller throttles the source. A sticky health flag
// reports a source that keeps repeating itself.
//
// Parameters:
//   WORDSIZE    data width
//   DEPTH       FIFO entries (power of two, >= 4)
//   LOWATER     occupancy at or below which refilling starts
//   STUCK_LIMIT consecutive repeated raw words that latch stuck_err
//
// Ports:
//   clk        sole clock, rising edge
//   reset      synchronous, active-high reset
//   rng_en     enable to the upstream rng block
//   rng_data   upstream data word, valid while rng_ready is high
//   rng_ready  upstream ready
//   req        consumer pop request
//   dout       head-of-FIFO word (don't-care while dout_valid is low)
//   dout_valid FIFO non-empty
//   count      current occupancy
//   full       count == DEPTH
//   stuck_err  sticky source-health failure
module rng_pool #(
    parameter int WORDSIZE    = 32,
    parameter int DEPTH       = 8,
    parameter int LOWATER     = 2,
    parameter int STUCK_LIMIT = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         rng_en,
    input  logic [WORDSIZE-1:0]          rng_data,
    input  logic                         rng_ready,
    input  logic                         req,
    output logic [WORDSIZE-1:0]          dout,
    output logic                         dout_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         stuck_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int RW = $clog2(STUCK_LIMIT + 1);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t               state;
    logic [WORDSIZE-1:0]  mem [DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [WORDSIZE-1:0]  last_raw;
    logic                 have_last;
    logic [RW-1:0]        rep_cnt;

    logic                 accept;
    logic                 is_repeat;
    logic                 push;
    logic                 pop;
    logic [CW-1:0]        next_count;
    logic [RW-1:0]        rep_next;

    assign full       = (count == CW'(DEPTH));
    assign dout_valid = (count != '0);
    // Head word comes straight from storage, so a push is visible on dout
    // in the cycle after the accepting edge.
    assign dout       = mem[rd_ptr];
    assign rng_en     = (state == FILL) && !stuck_err;

    assign accept     = rng_en && rng_ready && !full;
    // The very first word after reset has nothing to repeat.
    assign is_repeat  = have_last && (rng_data == last_raw);
    assign push       = accept && !is_repeat;
    assign pop        = req && dout_valid;
    assign next_count = count + CW'(push) - CW'(pop);

    // Saturating repeat counter; it only matters up to STUCK_LIMIT.
    assign rep_next   = (rep_cnt == RW'(STUCK_LIMIT)) ? rep_cnt : rep_cnt + RW'(1);

    // Fill controller. Decisions use the post-edge occupancy so that the
    // edge that drains to LOWATER (or fills to DEPTH) switches the state
    // immediately and rng_en follows in the very next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (next_count <= CW'(LOWATER)) begin
                        state <= FILL;
                    end
                end
                FILL: begin
                    if (next_count == CW'(DEPTH)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pointers, occupancy and source-health tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            last_raw  <= '0;
            have_last <= 1'b0;
            rep_cnt   <= '0;
            stuck_err <= 1'b0;
        end else begin
            count <= next_count;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (accept) begin
                if (is_repeat) begin
                    // Dropped word: last_raw is deliberately left alone so
                    // that a run of identical words keeps counting.
                    rep_cnt <= rep_next;
                    if (rep_next == RW'(STUCK_LIMIT)) begin
                        stuck_err <= 1'b1;
                    end
                end else begin
                    last_raw  <= rng_data;
                    have_last <= 1'b1;
                    rep_cnt   <= '0;
                end
            end
        end
    end

    // Storage is not reset; dout_valid masks stale contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rng_data ^ last_raw;
        end
    end

endmodule

// File: tb/tb_rng_pool.sv
// tb_rng_pool
// Self-checking bench for rng_pool. A queue-based reference model holds
// the expected FIFO contents, the whitening history, the repeat counter
// and the refill hysteresis. Outputs are compared against it every cycle
// on the falling edge. Directed checks at #1 after the rising edge cover
// the specific latencies and values from the design description.
module tb_rng_pool;

    localparam int WORDSIZE    = 32;
    localparam int DEPTH       = 8;
    localparam int LOWATER     = 2;
    localparam int STUCK_LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        rng_en;
    logic [31:0] rng_data;
    logic        rng_ready;
    logic        req;
    logic [31:0] dout;
    logic        dout_valid;
    logic [3:0]  count;
    logic        full;
    logic        stuck_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] model_q [$];
    logic [31:0] m_last;
    bit          m_have;
    int          m_rep;
    bit          m_stuck;
    bit          m_fill;
    bit          m_pushed;

    always #5 clk = ~clk;

    rng_pool #(
        .WORDSIZE    (WORDSIZE),
        .DEPTH       (DEPTH),
        .LOWATER     (LOWATER),
        .STUCK_LIMIT (STUCK_LIMIT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rng_en     (rng_en),
        .rng_data   (rng_data),
        .rng_ready  (rng_ready),
        .req        (req),
        .dout       (dout),
        .dout_valid (dout_valid),
        .count      (count),
        .full       (full),
        .stuck_err  (stuck_err)
    );

    task automatic checkValue(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput();
        checkValue("rng_en", 32'(rng_en), 32'(m_fill && !m_stuck));
        checkValue("dout_valid", 32'(dout_valid), 32'(model_q.size() != 0));
        checkValue("count", 32'(count), 32'(model_q.size()));
        checkValue("full", 32'(full), 32'(model_q.size() == DEPTH));
        checkValue("stuck_err", 32'(stuck_err), 32'(m_stuck));
        if (model_q.size() != 0) begin
            checkValue("dout", dout, model_q[0]);
        end
    endtask

    // One clock cycle: drive inputs on the falling edge, compare outputs,
    // then advance the model to what the coming rising edge should produce.
    task automatic applyStimulus(input bit rst, input bit rq, input bit rdy,
                                 input logic [31:0] data);
        bit en;
        bit acc;
        bit pop;
        bit rep;
        @(negedge clk);
        reset     = rst;
        req       = rq;
        rng_ready = rdy;
        rng_data  = data;
        checkOutput();
        en       = m_fill && !m_stuck;
        m_pushed = 1'b0;
        if (rst) begin
            model_q.delete();
            m_last  = 32'h0;
            m_have  = 1'b0;
            m_rep   = 0;
            m_stuck = 1'b0;
            m_fill  = 1'b0;
        end else begin
            acc      = en && rdy && (model_q.size() != DEPTH);
            pop      = rq && (model_q.size() != 0);
            rep      = acc && m_have && (data == m_last);
            m_pushed = acc && !rep;
            if (pop) begin
                void'(model_q.pop_front());
            end
            if (m_pushed) begin
                model_q.push_back(data ^ m_last);
                m_last = data;
                m_have = 1'b1;
                m_rep  = 0;
            end
            if (rep) begin
                m_rep++;
                if (m_rep >= STUCK_LIMIT) begin
                    m_stuck = 1'b1;
                end
            end
            if (!m_fill && model_q.size() <= LOWATER) begin
                m_fill = 1'b1;
            end else if (m_fill && model_q.size() == DEPTH) begin
                m_fill = 1'b0;
            end
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] exp_seq [8];
        logic [31:0] d;
        logic [31:0] a;
        logic [31:0] b;
        int          guard;

        exp_seq = '{32'd1, 32'd3, 32'd1, 32'd7, 32'd1, 32'd3, 32'd1, 32'd15};
        reset     = 1'b1;
        req       = 1'b0;
        rng_ready = 1'b1;
        rng_data  = 32'd9;
        m_last    = 32'h0;
        m_have    = 1'b0;
        m_rep     = 0;
        m_stuck   = 1'b0;
        m_fill    = 1'b0;
        m_pushed  = 1'b0;

        // Reset held two cycles with data offered, then release
        $display("[TB] reset check");
        applyStimulus(1'b1, 1'b0, 1'b1, 32'd9);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'd9);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'd9);
        settle();
        checkValue("en_after_release", 32'(rng_en), 32'd1);

        // Whitened fill with an incrementing source
        $display("[TB] whitened fill");
        d = 32'd1;
        guard = 0;
        while (model_q.size() < DEPTH && guard < 40) begin
            applyStimulus(1'b0, 1'b0, 1'b1, d);
            if (m_pushed) d++;
            guard++;
        end
        settle();
        checkValue("full_after_fill", 32'(full), 32'd1);
        checkValue("en_off_when_full", 32'(rng_en), 32'd0);
        checkValue("head_first", dout, exp_seq[0]);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b1, d + 32'd100);

        // Hysteresis: five pops keep the source off, the sixth restarts it
        $display("[TB] hysteresis");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
            settle();
            checkValue("pop_order", dout, exp_seq[i + 1]);
            if (i == 4) begin
                checkValue("count_after_5_pops", 32'(count), 32'd3);
                checkValue("en_after_5_pops", 32'(rng_en), 32'd0);
            end
            if (i == 5) begin
                checkValue("count_after_6_pops", 32'(count), 32'd2);
                checkValue("en_after_6_pops", 32'(rng_en), 32'd1);
            end
        end
        guard = 0;
        while (model_q.size() < DEPTH && guard < 40) begin
            applyStimulus(1'b0, 1'b0, 1'b1, d);
            if (m_pushed) d++;
            guard++;
        end
        settle();
        checkValue("refill_count", 32'(count), 32'd8);
        checkValue("refill_en_off", 32'(rng_en), 32'd0);
        guard = 0;
        while (model_q.size() != 0 && guard < 40) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
            guard++;
        end
        settle();
        checkValue("drained", 32'(dout_valid), 32'd0);

        // Stuck source
        $display("[TB] stuck source");
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'd5);
        repeat (8) applyStimulus(1'b0, 1'b0, 1'b1, 32'd5);
        settle();
        checkValue("stuck_count", 32'(count), 32'd1);
        checkValue("stuck_word", dout, 32'd5);
        checkValue("stuck_flag", 32'(stuck_err), 32'd1);
        checkValue("stuck_en_off", 32'(rng_en), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'd5);
        settle();
        checkValue("stuck_drain", 32'(count), 32'd0);
        checkValue("stuck_sticky", 32'(stuck_err), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        settle();
        checkValue("stuck_cleared", 32'(stuck_err), 32'd0);

        // Simultaneous push and pop at count 1, then req while empty
        $display("[TB] simultaneous events");
        a = $urandom;
        b = $urandom;
        if (b == a) b = ~a;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, a);
        settle();
        checkValue("single_count", 32'(count), 32'd1);
        checkValue("single_word", dout, a);
        applyStimulus(1'b0, 1'b1, 1'b1, b);
        settle();
        checkValue("pushpop_count", 32'(count), 32'd1);
        checkValue("pushpop_head", dout, a ^ b);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
        settle();
        checkValue("empty_req_count", 32'(count), 32'd0);
        checkValue("empty_req_valid", 32'(dout_valid), 32'd0);

        // Random traffic exercising pointer wrap-around
        $display("[TB] random wrap traffic");
        repeat (150) begin
            applyStimulus(1'b0, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) != 0), $urandom);
        end

        // Reset in the middle of a fill
        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        guard = 0;
        while (model_q.size() < 5 && guard < 40) begin
            applyStimulus(1'b0, 1'b0, 1'b1, $urandom);
            guard++;
        end
        settle();
        checkValue("midfill_count", 32'(count), 32'd5);
        checkValue("midfill_en", 32'(rng_en), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, $urandom);
        settle();
        checkValue("midreset_count", 32'(count), 32'd0);
        checkValue("midreset_valid", 32'(dout_valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hA5);
        settle();
        checkValue("raw_after_reset_valid", 32'(dout_valid), 32'd1);
        checkValue("raw_after_reset", dout, 32'hA5);
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rng_pool.md
# rng_pool

Buffering stage directly downstream of the `rng` block. It drives the RNG enable and captures each word the RNG presents with `ready`. It whitens each word by XOR with the previous raw word, rejects stuck (repeated) outputs, and holds the results in a small FIFO. Consumers draw words through a first-word-fall-through valid/request handshake. A hysteresis fill controller throttles the RNG, and a sticky health flag reports a stuck source.

## Interface
- `WORDSIZE`, 32: data width; matches `WORDSIZE` from `constants.vh`.
- `DEPTH`, 8: FIFO entries; power of two, ≥4.
- `LOWATER`, 2: refill threshold; 0 ≤ LOWATER < DEPTH-1.
- `STUCK_LIMIT`, 4: consecutive repeated raw words that latch `stuck_err`; ≥1.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rng_en`  out  1  enable to the upstream `rng` block.
- `rng_data`  in  WORDSIZE  upstream `dataout`.
- `rng_ready`  in  1  upstream `ready`; `rng_data` is valid while high.
- `req`  in  1  consumer pop request.
- `dout`  out  WORDSIZE  head-of-FIFO word.
- `dout_valid`  out  1  FIFO non-empty.
- `count`  out  $clog2(DEPTH+1)  current occupancy.
- `full`  out  1  count == DEPTH.
- `stuck_err`  out  1  sticky source-health failure.

## Operation
- **Fill FSM**, states IDLE and FILL; resets to IDLE.
  - IDLE → FILL when count ≤ LOWATER.
  - FILL → IDLE when the next count equals DEPTH.
  - Otherwise the state holds.
- `rng_en` = (state == FILL) && !stuck_err. It is decoded from registers, so it is 0 during reset and in the reset cycle.
- **Accept:** an accept happens at an edge where `rng_en && rng_ready && !full`. Words presented while `rng_en` is low are ignored.
- **Repeat detection on accept:**
  - Compare `rng_data` to `last_raw`, the previous accepted raw word.
  - A first accept after reset (`have_last` = 0) is never a repeat.
  - Repeat: drop the word; `rep_cnt` += 1 (saturating). When `rep_cnt` reaches STUCK_LIMIT, set `stuck_err`. `last_raw` is unchanged.
  - Distinct: push `rng_data ^ last_raw`, then set `last_raw` = `rng_data`, `have_last` = 1, `rep_cnt` = 0.
  - `last_raw` resets to 0, so the first word after reset is stored raw.
- **Pop:** a pop happens at an edge where `req && dout_valid`; `rd_ptr` advances.
  - `req` while empty is ignored; no underflow.
- **Simultaneous push and pop:** both take effect and `count` is unchanged. This holds with count == 1, where the pushed word becomes the head.
- **Pointers:** `$clog2(DEPTH)` bits, wrapping modulo DEPTH naturally. `count` is tracked separately.
- **`stuck_err`:**
  - Sticky until reset; the FIFO still drains normally.
  - No further accepts while it is set.
- **Reset, including mid-fill:**
  - Clears pointers, count, `last_raw`, `have_last`, `rep_cnt` and `stuck_err`; state → IDLE.
  - Buffered contents are discarded.

## Timing
- **Reset values:** `rng_en`=0, `dout_valid`=0, `count`=0, `full`=0, `stuck_err`=0. `dout` is don't-care while `dout_valid`=0, and memory is not cleared.
- **First cycle after reset release:** state goes IDLE→FILL at the first edge, so `rng_en`=1 one cycle after `reset` falls.
- **Push latency:** the word appears on `dout` with `dout_valid`=1 in the cycle after the accepting edge.
- **Pop:** `dout` shows the next entry in the cycle after the popping edge. `dout` is driven from storage, with no output register.
- **Full:** when the DEPTH-th push happens, `full` is 1 and `rng_en` is 0 in the next cycle. No word is lost.
- **Refill:** the edge at which count drops to ≤ LOWATER moves the state to FILL. `rng_en` rises in the following cycle.
- **Stuck:** `stuck_err` and `rng_en`=0 are seen in the cycle after the STUCK_LIMIT-th repeat edge.

## Test plan
- **Reset check:** hold `reset` 2 cycles with `rng_ready`=1 and data 9. All outputs must be at reset values and `count` must stay 0. `rng_en` must be 1 exactly one cycle after release.
- **Whitened fill:** defaults, `rng_ready`=1, `rng_data` = 1, 2, 3, … one value per cycle while `rng_en`=1.
  - Popped sequence must be 1, 3, 1, 7, 1, 3, 1, 15.
  - `full`=1 after 8 accepts; `rng_en`=0 the next cycle.
  - Data offered afterwards must be ignored.
- **Hysteresis:** from full, pop 5 (count 3): `rng_en` stays 0. Pop a 6th (count 2): `rng_en`=1 the cycle after. Refill must stop again at count 8.
- **Stuck source:** feed constant 5 with `rng_ready`=1.
  - Exactly one word (5) is stored.
  - After 4 repeats, `stuck_err`=1 and `rng_en`=0.
  - Word 5 still pops.
  - Reset clears `stuck_err`.
- **Simultaneous events:** hold count 1 and issue push and pop in the same cycle. `count` must stay 1 and `dout` must show the new word next cycle. Also: `req` when empty leaves `count`=0 with no pointer motion. Also: run ≥3·DEPTH push/pop cycles and confirm wrap-around order is preserved.
- **Reset mid-operation:** assert `reset` at count 5 while in FILL. Next cycle `count`=0 and `dout_valid`=0. The first subsequent word (e.g. 0xA5) is stored raw as 0xA5.
